// File: rtl/ahb_ls_arbiter_if.sv
// Bundle of CPU load/store request channels and the two bridge channels
// seen by ahb_ls_arbiter; slave = arbiter view, master = CPU/bridge view.
interface ahb_ls_arbiter_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic        ld_done;
  logic        ld_err;
  logic [31:0] ld_data;

  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ack;
  logic        st_done;
  logic        st_err;

  logic        br_ld_set_busy;
  logic [31:0] br_ld_addr;
  logic        br_ld_busy;
  logic [31:0] br_ld_data;

  logic        br_st_set_busy;
  logic [31:0] br_st_addr;
  logic [31:0] br_st_data;
  logic        br_st_busy;

  modport slave (
    input  ld_req, ld_addr, st_req, st_addr, st_data,
    input  br_ld_busy, br_ld_data, br_st_busy,
    output ld_ack, ld_done, ld_err, ld_data,
    output st_ack, st_done, st_err,
    output br_ld_set_busy, br_ld_addr,
    output br_st_set_busy, br_st_addr, br_st_data
  );

  modport master (
    output ld_req, ld_addr, st_req, st_addr, st_data,
    output br_ld_busy, br_ld_data, br_st_busy,
    input  ld_ack, ld_done, ld_err, ld_data,
    input  st_ack, st_done, st_err,
    input  br_ld_set_busy, br_ld_addr,
    input  br_st_set_busy, br_st_addr, br_st_data
  );
endinterface

// File: rtl/ahb_ls_arbiter.sv
// Round-robin arbiter steering CPU loads/stores onto two AHB bridges, one transaction at a time.
// Optional WAIT timeout is compiled in with the AHB_LS_ARB_TIMEOUT_EN macro.
module ahb_ls_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_ls_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sel;
  logic        last_grant;
  logic        grant_vld;
  logic        grant_sel;
  logic        sel_busy;
  logic        wait_done;
  logic        timeout_hit;
  logic [31:0] ld_addr_q;
  logic [31:0] st_addr_q;
  logic [31:0] st_data_q;
  logic [31:0] ld_data_q;

  // On a tie the side that did not win last time is served.
  assign grant_vld = bus.ld_req | bus.st_req;
  assign grant_sel = (bus.ld_req & bus.st_req) ? ~last_grant : bus.st_req;
  assign sel_busy  = sel ? bus.br_st_busy : bus.br_ld_busy;
  assign wait_done = (state == S_WAIT) & (~sel_busy | timeout_hit);

`ifdef AHB_LS_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic       timed_out;

  assign timeout_hit = (state == S_WAIT) & sel_busy & ((wait_cnt + 8'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt  <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == S_ISSUE) begin
      wait_cnt  <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == S_WAIT) begin
      wait_cnt  <= wait_cnt + 8'd1;
      timed_out <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and per-transaction control
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && grant_vld) begin
        sel <= grant_sel;
      end
      if (state == S_ISSUE) begin
        last_grant <= sel;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_vld) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_done) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bridge command and load result registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ld_addr_q <= 32'd0;
      st_addr_q <= 32'd0;
      st_data_q <= 32'd0;
      ld_data_q <= 32'd0;
    end else begin
      if ((state == S_IDLE) && grant_vld) begin
        if (grant_sel) begin
          st_addr_q <= bus.st_addr;
          st_data_q <= bus.st_data;
        end else begin
          ld_addr_q <= bus.ld_addr;
        end
      end
      if (wait_done && !sel) begin
        ld_data_q <= timeout_hit ? 32'd0 : bus.br_ld_data;
      end
    end
  end

  assign bus.br_ld_addr = ld_addr_q;
  assign bus.br_st_addr = st_addr_q;
  assign bus.br_st_data = st_data_q;
  assign bus.ld_data    = ld_data_q;

  // Output decode: pulses come straight from the single-cycle ISSUE/RESP states
  always_comb begin
    bus.ld_ack         = 1'b0;
    bus.st_ack         = 1'b0;
    bus.br_ld_set_busy = 1'b0;
    bus.br_st_set_busy = 1'b0;
    bus.ld_done        = 1'b0;
    bus.st_done        = 1'b0;
    bus.ld_err         = 1'b0;
    bus.st_err         = 1'b0;
    case (state)
      S_ISSUE: begin
        bus.ld_ack         = ~sel;
        bus.br_ld_set_busy = ~sel;
        bus.st_ack         = sel;
        bus.br_st_set_busy = sel;
      end
      S_RESP: begin
        bus.ld_done = ~sel;
        bus.st_done = sel;
`ifdef AHB_LS_ARB_TIMEOUT_EN
        bus.ld_err  = ~sel & timed_out;
        bus.st_err  = sel & timed_out;
`endif
      end
      default: ;
    endcase
  end

  a_ack_single: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (bus.ld_ack | bus.st_ack) |=> !(bus.ld_ack | bus.st_ack));
  a_done_single: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (bus.ld_done | bus.st_done) |=> !(bus.ld_done | bus.st_done));
  a_set_busy_excl: assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(bus.br_ld_set_busy & bus.br_st_set_busy));

endmodule

// File: tb/tb_ahb_ls_arbiter.sv
// Randomized bench for ahb_ls_arbiter with a transaction-level timing model and directed scenarios.
module tb_ahb_ls_arbiter;

  logic HCLK = 1'b0;
  logic HRESETn;

  ahb_ls_arbiter_if bus ();

  ahb_ls_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

`ifdef AHB_LS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_LIM = 8;

  int n_chk;
  int n_pass;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  int          k;
  int          pct;
  int          force_b;
  bit          force_d_en;
  logic [31:0] force_d;
  bit          noise_en;

  // bridge models
  int          bl_cnt, bs_cnt, bl_len, bs_len;
  bit          bl_pend, bs_pend;
  logic [31:0] bl_dat;

  // reference model: one transaction in flight, timed from its grant edge
  bit          m_act, m_sel, m_last, m_err;
  int          m_e, m_done_k;
  logic [31:0] m_br_ld_addr, m_br_st_addr, m_br_st_data, m_ld_data, m_ld_next;

  // observations
  bit          ld_ack_s, st_ack_s;
  int          n_ld_sb, n_st_sb, n_ld_done, n_st_done, n_ld_err, k_st_done;
  bit          grant_q[$];

  function automatic logic [7:0] ctl_vec();
    return {bus.ld_ack, bus.ld_done, bus.ld_err, bus.br_ld_set_busy,
            bus.st_ack, bus.st_done, bus.st_err, bus.br_st_set_busy};
  endfunction

  task automatic clear_counts();
    n_ld_sb = 0; n_st_sb = 0; n_ld_done = 0; n_st_done = 0; n_ld_err = 0;
    k_st_done = -1;
    grant_q.delete();
  endtask

  task automatic bridge_update();
    if (bl_pend) begin
      bl_cnt = bl_len; bl_pend = 1'b0; bus.br_ld_data = bl_dat;
    end else if (bl_cnt > 0) bl_cnt--;
    if (bs_pend) begin
      bs_cnt = bs_len; bs_pend = 1'b0;
    end else if (bs_cnt > 0) bs_cnt--;
    bus.br_ld_busy = (bl_cnt > 0) ||
                     (noise_en && !(m_act && !m_sel) && ($urandom_range(0, 1) == 1));
    bus.br_st_busy = (bs_cnt > 0) ||
                     (noise_en && !(m_act && m_sel) && ($urandom_range(0, 1) == 1));
    if (noise_en && !(m_act && !m_sel) && (bl_cnt == 0)) bus.br_ld_data = $urandom;
  endtask

  task automatic model_step();
    int b;
    logic [31:0] d;
    if (m_act && (k >= m_done_k + 2)) m_act = 1'b0;
    if (!m_act && (bus.ld_req || bus.st_req)) begin
      m_sel  = (bus.ld_req && bus.st_req) ? ~m_last : bus.st_req;
      m_last = m_sel;
      m_e    = k;
      m_act  = 1'b1;
      b = (force_b > 0) ? force_b : int'($urandom_range(1, 6));
      d = force_d_en ? force_d : $urandom;
      if (TO_EN && (b >= TO_LIM)) begin
        m_done_k = k + 1 + TO_LIM; m_err = 1'b1;
      end else begin
        m_done_k = k + 2 + b; m_err = 1'b0;
      end
      if (!m_sel) begin
        m_br_ld_addr = bus.ld_addr; bl_len = b; bl_dat = d;
        m_ld_next = m_err ? 32'd0 : d;
      end else begin
        m_br_st_addr = bus.st_addr; m_br_st_data = bus.st_data; bs_len = b;
      end
    end
    if (m_act && !m_sel && (k == m_done_k)) m_ld_data = m_ld_next;
  endtask

  task automatic observe_and_check();
    bit iss, dn;
    logic [7:0] exp_ctl;
    iss = m_act && (k == m_e);
    dn  = m_act && (k == m_done_k);
    exp_ctl = {iss && !m_sel, dn && !m_sel, dn && !m_sel && m_err, iss && !m_sel,
               iss && m_sel,  dn && m_sel,  dn && m_sel && m_err,  iss && m_sel};
    chk("ctl", {56'd0, ctl_vec()}, {56'd0, exp_ctl});
    chk("ld_path", {bus.ld_data, bus.br_ld_addr}, {m_ld_data, m_br_ld_addr});
    chk("st_path", {bus.br_st_addr, bus.br_st_data}, {m_br_st_addr, m_br_st_data});
    ld_ack_s = bus.ld_ack;
    st_ack_s = bus.st_ack;
    if (bus.ld_ack) grant_q.push_back(1'b0);
    if (bus.st_ack) grant_q.push_back(1'b1);
    if (bus.br_ld_set_busy) begin bl_pend = 1'b1; n_ld_sb++; end
    if (bus.br_st_set_busy) begin bs_pend = 1'b1; n_st_sb++; end
    if (bus.ld_done) n_ld_done++;
    if (bus.ld_err) n_ld_err++;
    if (bus.st_done) begin n_st_done++; k_st_done = k; end
  endtask

  task automatic drive_reqs();
    if (bus.ld_req && ld_ack_s) bus.ld_req = 1'b0;
    if (!bus.ld_req) begin
      bus.ld_addr = $urandom;
      if ((pct > 0) && (int'($urandom_range(0, 99)) < pct)) bus.ld_req = 1'b1;
    end
    if (bus.st_req && st_ack_s) bus.st_req = 1'b0;
    if (!bus.st_req) begin
      bus.st_addr = $urandom;
      bus.st_data = $urandom;
      if ((pct > 0) && (int'($urandom_range(0, 99)) < pct)) bus.st_req = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    k++;
    #1;
    bridge_update();
    model_step();
    observe_and_check();
    drive_reqs();
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    bus.ld_req = 1'b0; bus.st_req = 1'b0;
    bus.br_ld_busy = 1'b0; bus.br_st_busy = 1'b0;
    bl_cnt = 0; bs_cnt = 0; bl_pend = 1'b0; bs_pend = 1'b0;
    #1;
    chk("rst_ctl", {56'd0, ctl_vec()}, 64'd0);
    chk("rst_ld", {bus.ld_data, bus.br_ld_addr}, 64'd0);
    chk("rst_st", {bus.br_st_addr, bus.br_st_data}, 64'd0);
    m_act = 1'b0; m_last = 1'b1; m_err = 1'b0;
    m_ld_data = 32'd0; m_br_ld_addr = 32'd0; m_br_st_addr = 32'd0; m_br_st_data = 32'd0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  bit exp_order [4];
  int k0;

  initial begin
    k = 0; pct = 0; force_b = 0; force_d_en = 1'b0; force_d = 32'd0; noise_en = 1'b0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    bus.ld_req = 1'b0; bus.ld_addr = 32'd0;
    bus.st_req = 1'b0; bus.st_addr = 32'd0; bus.st_data = 32'd0;
    bus.br_ld_busy = 1'b0; bus.br_ld_data = 32'd0; bus.br_st_busy = 1'b0;
    clear_counts();
    HRESETn = 1'b1;
    #2;
    do_reset();

    // single load, bridge busy 3 cycles
    clear_counts();
    force_b = 3; force_d = 32'hDEAD_BEEF; force_d_en = 1'b1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_1000;
    repeat (10) step();
    chk("load_sb_pulses", 64'(n_ld_sb), 64'd1);
    chk("load_br_addr", {32'd0, bus.br_ld_addr}, 64'h1000);
    chk("load_data", {32'd0, bus.ld_data}, 64'hDEAD_BEEF);
    chk("load_done_cnt", 64'(n_ld_done), 64'd1);
    force_d_en = 1'b0;

    // single store, bridge busy 1 cycle
    clear_counts();
    force_b = 1;
    k0 = k;
    bus.st_req = 1'b1; bus.st_addr = 32'h20; bus.st_data = 32'h55AA_55AA;
    repeat (8) step();
    chk("store_latency", 64'(k_st_done - k0), 64'd4);
    chk("store_br", {bus.br_st_addr, bus.br_st_data}, 64'h0000_0020_55AA_55AA);
    chk("store_no_ld_sb", 64'(n_ld_sb), 64'd0);
    chk("store_sb_pulses", 64'(n_st_sb), 64'd1);

    // bridge stuck busy: timeout build finishes with error, default build keeps waiting
    clear_counts();
    force_b = 12;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_4000;
    repeat (11) step();
`ifdef AHB_LS_ARB_TIMEOUT_EN
    chk("timeout_done", 64'(n_ld_done), 64'd1);
    chk("timeout_err", 64'(n_ld_err), 64'd1);
    chk("timeout_data", {32'd0, bus.ld_data}, 64'd0);
`else
    chk("no_timeout_done", 64'(n_ld_done), 64'd0);
    chk("no_timeout_err", 64'(n_ld_err), 64'd0);
`endif
    do_reset();

    // reset while waiting on the bridge, then a fresh load
    clear_counts();
    force_b = 6;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_5000;
    repeat (3) step();
    do_reset();
    clear_counts();
    repeat (8) step();
    chk("abort_no_done", 64'(n_ld_done), 64'd0);
    force_b = 2;
    bus.ld_req = 1'b1; bus.ld_addr = 32'hCAFE_0000;
    repeat (8) step();
    chk("after_rst_done", 64'(n_ld_done), 64'd1);
    chk("after_rst_addr", {32'd0, bus.br_ld_addr}, 64'hCAFE_0000);

    // load pulse while a store is in WAIT is ignored
    clear_counts();
    force_b = 5;
    bus.st_req = 1'b1; bus.st_addr = 32'h0000_6000; bus.st_data = 32'h1234_5678;
    repeat (3) step();
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_3000;
    step();
    bus.ld_req = 1'b0;
    repeat (8) step();
    chk("pulse_no_ld_sb", 64'(n_ld_sb), 64'd0);
    chk("pulse_st_done", 64'(n_st_done), 64'd1);

    // both requests held after reset: strict alternation starting with load
    do_reset();
    clear_counts();
    force_b = 1; pct = 100;
    bus.ld_req = 1'b1; bus.st_req = 1'b1;
    repeat (22) step();
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk("order_count_ok", 64'(grant_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order%0d", i), (i < grant_q.size()) ? {63'd0, grant_q[i]} : 64'hx,
          {63'd0, exp_order[i]});
    end
    pct = 0;
    repeat (10) step();

    // randomized traffic with noise on the idle bridge
    clear_counts();
    force_b = 0; pct = 35; noise_en = 1'b1;
    repeat (1500) step();
    pct = 0; noise_en = 1'b0;
    repeat (20) step();
    chk("rand_ld_activity", 64'(n_ld_done > 20), 64'd1);
    chk("rand_st_activity", 64'(n_st_done > 20), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
